// File: rtl/ahbl_timer_slave_if.sv
// AHB-Lite slave-side bus bundle for the peripheral timer.
// The master modport drives the request; the slave returns ready and read data.
interface ahbl_timer_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/ahbl_timer_slave.sv
// AHB-Lite 32-bit down-counting timer with prescaler, one-shot mode
// and a level interrupt; zero-wait-state register interface.
module ahbl_timer_slave #(
    parameter int PRE_W = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahbl_timer_slave_if.slave   bus,
    output logic                IRQ
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PRE    = 3'd1;
    localparam logic [2:0] A_LOAD   = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic             dp_valid_q, dp_valid_d;
    logic             dp_write_q, dp_write_d;
    logic [2:0]       dp_addr_q,  dp_addr_d;
    logic             en_q, en_d;
    logic             oneshot_q, oneshot_d;
    logic             ie_q, ie_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]      load_q, load_d;
    logic [31:0]      count_q, count_d;
    logic             to_q, to_d;

    logic             wr;
    logic             wr_ctrl, wr_pre, wr_load, wr_count, wr_status;
    logic             tick;
    logic [31:0]      pre_rd;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign unused_bits = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0]};

    always_comb begin
        dp_valid_d = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        if (dp_valid_d) begin
            dp_write_d = bus.HWRITE;
            dp_addr_d  = bus.HADDR[4:2];
        end
    end

    assign wr        = dp_valid_q & dp_write_q;
    assign wr_ctrl   = wr && (dp_addr_q == A_CTRL);
    assign wr_pre    = wr && (dp_addr_q == A_PRE);
    assign wr_load   = wr && (dp_addr_q == A_LOAD);
    assign wr_count  = wr && (dp_addr_q == A_COUNT);
    assign wr_status = wr && (dp_addr_q == A_STATUS);

    assign tick = en_q && (pre_cnt_q == pre_q);

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        ie_d      = ie_q;
        pre_d     = pre_q;
        load_d    = load_q;
        count_d   = count_q;
        to_d      = to_q;
        pre_cnt_d = pre_cnt_q;

        if (!en_q || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        if (wr_status && bus.HWDATA[0]) begin
            to_d = 1'b0;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                to_d = 1'b1;
                if (oneshot_q) begin
                    en_d = 1'b0;
                end else begin
                    count_d = load_q;
                end
            end
        end

        // Bus writes are applied last so they override timer side effects.
        if (wr_ctrl) begin
            en_d      = bus.HWDATA[0];
            oneshot_d = bus.HWDATA[1];
            ie_d      = bus.HWDATA[2];
            if (!bus.HWDATA[0]) begin
                pre_cnt_d = '0;
            end
        end
        if (wr_pre) begin
            pre_d = bus.HWDATA[PRE_W-1:0];
        end
        if (wr_load) begin
            load_d = bus.HWDATA;
        end
        if (wr_count) begin
            count_d = bus.HWDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 3'd0;
            en_q       <= 1'b0;
            oneshot_q  <= 1'b0;
            ie_q       <= 1'b0;
            pre_q      <= '0;
            pre_cnt_q  <= '0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            to_q       <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            en_q       <= en_d;
            oneshot_q  <= oneshot_d;
            ie_q       <= ie_d;
            pre_q      <= pre_d;
            pre_cnt_q  <= pre_cnt_d;
            load_q     <= load_d;
            count_q    <= count_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        pre_rd = 32'd0;
        pre_rd[PRE_W-1:0] = pre_q;
    end

    always_comb begin
        rdata = 32'd0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                A_CTRL:   rdata = {29'd0, ie_q, oneshot_q, en_q};
                A_PRE:    rdata = pre_rd;
                A_LOAD:   rdata = load_q;
                A_COUNT:  rdata = count_q;
                A_STATUS: rdata = {31'd0, to_q};
                default:  rdata = 32'd0;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign IRQ           = to_q & ie_q;

endmodule
